// File: rtl/credit_link_slice.sv
// Link stage between router ports and inter-router wiring: retimes flits forward and
// credits backward, tracks downstream credits per port/VC, flags credit protocol
// violations and reports per-port link idleness.
module credit_link_slice #(
   parameter int unsigned NUM_PORTS       = 5,
   parameter int unsigned NUM_VCS         = 4,
   parameter int unsigned FLIT_DATA_WIDTH = 64,
   parameter int unsigned BUFFER_SIZE     = 64,
   parameter int unsigned PIPE_STAGES     = 1,
   parameter int unsigned IDLE_THRESHOLD  = 8,
   parameter int unsigned ERROR_STICKY    = 1,
   localparam int unsigned VC_W = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
   localparam int unsigned CW   = 1 + VC_W + FLIT_DATA_WIDTH,
   localparam int unsigned FW   = 1 + VC_W
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_PORTS*CW-1:0]        channel_in_ip,
   input  logic [NUM_PORTS*FW-1:0]        flow_ctrl_out_ip,
   output logic [NUM_PORTS*CW-1:0]        channel_out_op,
   output logic [NUM_PORTS*FW-1:0]        flow_ctrl_in_op,
   output logic [NUM_PORTS*NUM_VCS-1:0]   credit_avail_op,
   output logic [NUM_PORTS-1:0]           link_idle_op,
   output logic                           error
);

   localparam int unsigned CPV     = BUFFER_SIZE / NUM_VCS;
   localparam int unsigned CNT_W   = $clog2(CPV + 1);
   localparam int unsigned IDL_W   = $clog2(IDLE_THRESHOLD + 1);
   // When NUM_VCS fills the VC field no out-of-range encoding exists.
   localparam bit          VC_FULL = (NUM_VCS == (1 << VC_W));

   // ---------------- Retiming pipelines ----------------
   if (PIPE_STAGES == 0) begin : g_pass
      assign channel_out_op  = channel_in_ip;
      assign flow_ctrl_in_op = flow_ctrl_out_ip;
   end else begin : g_pipe
      logic [NUM_PORTS*CW-1:0] ch_q [PIPE_STAGES];
      logic [NUM_PORTS*FW-1:0] fc_q [PIPE_STAGES];

      // Shift flits and credits one stage per cycle; reset flushes everything in flight.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
               ch_q[i] <= '0;
               fc_q[i] <= '0;
            end
         end else begin
            ch_q[0] <= channel_in_ip;
            fc_q[0] <= flow_ctrl_out_ip;
            for (int i = 1; i < PIPE_STAGES; i++) begin
               ch_q[i] <= ch_q[i-1];
               fc_q[i] <= fc_q[i-1];
            end
         end
      end

      assign channel_out_op  = ch_q[PIPE_STAGES-1];
      assign flow_ctrl_in_op = fc_q[PIPE_STAGES-1];
   end

   // ---------------- Field decode ----------------
   logic [NUM_PORTS-1:0] out_vld, crd_vld, bad_out_vc, bad_crd_vc;
   logic [VC_W-1:0]      out_vc [NUM_PORTS];
   logic [VC_W-1:0]      crd_vc [NUM_PORTS];
   logic [NUM_VCS-1:0]   dec_v  [NUM_PORTS];
   logic [NUM_VCS-1:0]   inc_v  [NUM_PORTS];

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
      // Debits come from flits leaving the slice, credits from the unretimed downstream return.
      assign out_vld[p] = channel_out_op[p*CW];
      assign out_vc[p]  = channel_out_op[p*CW+1 +: VC_W];
      assign crd_vld[p] = flow_ctrl_out_ip[p*FW];
      assign crd_vc[p]  = flow_ctrl_out_ip[p*FW+1 +: VC_W];
      if (VC_FULL) begin : g_vc_ok
         assign bad_out_vc[p] = 1'b0;
         assign bad_crd_vc[p] = 1'b0;
      end else begin : g_vc_chk
         assign bad_out_vc[p] = out_vld[p] && (32'(out_vc[p]) >= NUM_VCS);
         assign bad_crd_vc[p] = crd_vld[p] && (32'(crd_vc[p]) >= NUM_VCS);
      end
      for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
         assign dec_v[p][v] = out_vld[p] && (out_vc[p] == VC_W'(v));
         assign inc_v[p][v] = crd_vld[p] && (crd_vc[p] == VC_W'(v));
      end
   end

   // ---------------- Credit counters ----------------
   logic [CNT_W-1:0] cnt_q [NUM_PORTS][NUM_VCS];
   logic [CNT_W-1:0] cnt_d [NUM_PORTS][NUM_VCS];
   logic             viol;

   // Next credit counts; out-of-range updates hold the count and raise a violation.
   always_comb begin
      viol = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (bad_out_vc[p] || bad_crd_vc[p]) viol = 1'b1;
         for (int v = 0; v < NUM_VCS; v++) begin
            cnt_d[p][v] = cnt_q[p][v];
            if (dec_v[p][v] && !inc_v[p][v]) begin
               if (cnt_q[p][v] == '0) viol = 1'b1;
               else                   cnt_d[p][v] = cnt_q[p][v] - 1'b1;
            end else if (inc_v[p][v] && !dec_v[p][v]) begin
               if (cnt_q[p][v] == CNT_W'(CPV)) viol = 1'b1;
               else                            cnt_d[p][v] = cnt_q[p][v] + 1'b1;
            end
         end
      end
   end

   // Register credit counts; reset restores a full downstream buffer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int p = 0; p < NUM_PORTS; p++)
            for (int v = 0; v < NUM_VCS; v++)
               cnt_q[p][v] <= CNT_W'(CPV);
      end else begin
         cnt_q <= cnt_d;
      end
   end

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_avail
      for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
         assign credit_avail_op[p*NUM_VCS+v] = (cnt_q[p][v] != '0);
      end
   end

   // ---------------- Link idle tracking ----------------
   logic [IDL_W-1:0]     idle_q [NUM_PORTS];
   logic [IDL_W-1:0]     idle_d [NUM_PORTS];
   logic [NUM_PORTS-1:0] link_idle_q;

   // Saturating count of consecutive inactive cycles per port.
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (out_vld[p] || crd_vld[p])                     idle_d[p] = '0;
         else if (idle_q[p] != IDL_W'(IDLE_THRESHOLD))     idle_d[p] = idle_q[p] + 1'b1;
         else                                              idle_d[p] = idle_q[p];
      end
   end

   // Register idle counters and the idle flag derived from the next count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int p = 0; p < NUM_PORTS; p++) idle_q[p] <= '0;
         link_idle_q <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            idle_q[p]      <= idle_d[p];
            link_idle_q[p] <= (idle_d[p] == IDL_W'(IDLE_THRESHOLD));
         end
      end
   end

   assign link_idle_op = link_idle_q;

   // ---------------- Error flag ----------------
   logic err_q;

   // Sticky mode accumulates violations; pulse mode mirrors last cycle's violation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                 err_q <= 1'b0;
      else if (ERROR_STICKY != 0) err_q <= err_q | viol;
      else                        err_q <= viol;
   end

   assign error = err_q;

endmodule

// File: tb/tb_credit_link_slice.sv
// Self-checking bench for credit_link_slice: default instance plus a pulse-error instance and
// a three-stage instance sharing the same stimulus, checked against a behavioural model.
module tb_credit_link_slice;

   localparam int NP  = 5;
   localparam int NV  = 4;
   localparam int DW  = 64;
   localparam int CW  = 67;
   localparam int FW  = 3;
   localparam int CPV = 16;
   localparam int TH  = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [NP*CW-1:0] ch_in = '0;
   logic [NP*FW-1:0] fc_in = '0;

   logic [NP*CW-1:0] ch_out, ns_ch_out, p3_ch_out;
   logic [NP*FW-1:0] fc_out, ns_fc_out, p3_fc_out;
   logic [NP*NV-1:0] cav, ns_cav, p3_cav;
   logic [NP-1:0]    idle, ns_idle, p3_idle;
   logic             err, ns_err, p3_err;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   int               cnt [NP][NV];
   int               idl [NP];
   bit               err_m, err_ns_m;
   logic [NP*CW-1:0] ch1;
   logic [NP*FW-1:0] fc1;
   logic [NP*CW-1:0] q3 [$];
   logic [NP*FW-1:0] fq3 [$];

   always #5 clk = ~clk;

   credit_link_slice dut (
      .clk(clk), .reset(reset), .channel_in_ip(ch_in), .flow_ctrl_out_ip(fc_in),
      .channel_out_op(ch_out), .flow_ctrl_in_op(fc_out), .credit_avail_op(cav),
      .link_idle_op(idle), .error(err)
   );

   credit_link_slice #(.ERROR_STICKY(0)) dut_ns (
      .clk(clk), .reset(reset), .channel_in_ip(ch_in), .flow_ctrl_out_ip(fc_in),
      .channel_out_op(ns_ch_out), .flow_ctrl_in_op(ns_fc_out), .credit_avail_op(ns_cav),
      .link_idle_op(ns_idle), .error(ns_err)
   );

   credit_link_slice #(.PIPE_STAGES(3)) dut_p3 (
      .clk(clk), .reset(reset), .channel_in_ip(ch_in), .flow_ctrl_out_ip(fc_in),
      .channel_out_op(p3_ch_out), .flow_ctrl_in_op(p3_fc_out), .credit_avail_op(p3_cav),
      .link_idle_op(p3_idle), .error(p3_err)
   );

   function automatic logic [NP*CW-1:0] add_flit(input logic [NP*CW-1:0] base, input int p,
                                                 input int vc, input logic [DW-1:0] d);
      base[p*CW +: CW] = {d, 2'(vc), 1'b1};
      return base;
   endfunction

   function automatic logic [NP*FW-1:0] add_crd(input logic [NP*FW-1:0] base, input int p,
                                                input int vc);
      base[p*FW +: FW] = {2'(vc), 1'b1};
      return base;
   endfunction

   function automatic logic [NP*NV-1:0] exp_cav();
      logic [NP*NV-1:0] r;
      for (int p = 0; p < NP; p++)
         for (int v = 0; v < NV; v++)
            r[p*NV+v] = (cnt[p][v] != 0);
      return r;
   endfunction

   function automatic logic [NP-1:0] exp_idle();
      logic [NP-1:0] r;
      for (int p = 0; p < NP; p++) r[p] = (idl[p] == TH);
      return r;
   endfunction

   task automatic model_reset();
      for (int p = 0; p < NP; p++) begin
         idl[p] = 0;
         for (int v = 0; v < NV; v++) cnt[p][v] = CPV;
      end
      err_m = 1'b0;
      err_ns_m = 1'b0;
      ch1 = '0;
      fc1 = '0;
      q3 = '{'0, '0, '0};
      fq3 = '{'0, '0, '0};
   endtask

   // Apply one cycle of inputs, advance the model across the clock edge, return at negedge.
   task automatic drive(input logic [NP*CW-1:0] ch, input logic [NP*FW-1:0] fc);
      bit viol = 1'b0;
      logic [NP*CW-1:0] tc;
      logic [NP*FW-1:0] tf;
      ch_in = ch;
      fc_in = fc;
      for (int p = 0; p < NP; p++) begin
         bit ov = ch1[p*CW];
         int ovc = int'(ch1[p*CW+1 +: 2]);
         bit fv = fc[p*FW];
         int fvc = int'(fc[p*FW+1 +: 2]);
         for (int v = 0; v < NV; v++) begin
            int n = cnt[p][v] + ((fv && fvc == v) ? 1 : 0) - ((ov && ovc == v) ? 1 : 0);
            if (n < 0 || n > CPV) viol = 1'b1;
            else cnt[p][v] = n;
         end
         if (ov || fv) idl[p] = 0;
         else if (idl[p] < TH) idl[p] = idl[p] + 1;
      end
      err_m = err_m | viol;
      err_ns_m = viol;
      ch1 = ch;
      fc1 = fc;
      q3.push_back(ch);
      tc = q3.pop_front();
      fq3.push_back(fc);
      tf = fq3.pop_front();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      ch_in = '0;
      fc_in = '0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      model_reset();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      ch_in = '0;
      fc_in = '0;
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({ch_out, fc_out, idle, err} !== '0) begin
         errors++;
         $display("FAIL reset_outs_in_reset: got ch=%h fc=%h idle=%b err=%b exp all 0",
                  ch_out, fc_out, idle, err);
      end
      checks++;
      if (cav !== {NP*NV{1'b1}}) begin
         errors++;
         $display("FAIL reset_cav_in_reset: got %h exp all ones", cav);
      end
      checks++;
      if (p3_ch_out !== '0 || p3_fc_out !== '0 || ns_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_other_inst: got p3ch=%h p3fc=%h nserr=%b exp 0",
                  p3_ch_out, p3_fc_out, ns_err);
      end
      model_reset();
      reset = 1'b1;
      drive('0, '0);
      checks++;
      if ({ch_out, fc_out, idle, err} !== '0 || cav !== {NP*NV{1'b1}}) begin
         errors++;
         $display("FAIL reset_after_release: got ch=%h fc=%h cav=%h idle=%b err=%b exp 0/ones",
                  ch_out, fc_out, cav, idle, err);
      end
   endtask

   // Sixteen back-to-back flits on port 2 VC 1 drain all of that VC's credits.
   task automatic test_back_to_back();
      logic [NP*CW-1:0] f;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         f = add_flit('0, 2, 1, {$urandom, $urandom});
         drive(f, '0);
         checks++;
         if (ch_out !== f) begin
            errors++;
            $display("FAIL b2b_flit%0d: got %h exp %h", i, ch_out, f);
         end
      end
      drive('0, '0);
      checks++;
      if (cav !== ~20'h00200 || err !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drained: got cav=%h err=%b exp cav=%h err=0", cav, err, ~20'h00200);
      end
   endtask

   // A 17th flit underflows the drained VC; sticky error holds, pulse error lasts one cycle.
   task automatic test_underflow();
      logic [NP*CW-1:0] f;
      f = add_flit('0, 2, 1, {$urandom, $urandom});
      drive(f, '0);
      checks++;
      if (ch_out !== f || err !== 1'b0) begin
         errors++;
         $display("FAIL uf_exit: got ch=%h err=%b exp ch=%h err=0", ch_out, err, f);
      end
      drive('0, '0);
      checks++;
      if (err !== 1'b1 || ns_err !== 1'b1 || cav[9] !== 1'b0) begin
         errors++;
         $display("FAIL uf_flag: got err=%b nserr=%b cav9=%b exp 1 1 0", err, ns_err, cav[9]);
      end
      for (int i = 0; i < 3; i++) begin
         drive('0, '0);
         checks++;
         if (err !== 1'b1 || ns_err !== 1'b0) begin
            errors++;
            $display("FAIL uf_hold%0d: got err=%b nserr=%b exp 1 0", i, err, ns_err);
         end
      end
   endtask

   // Simultaneous debit/credit holds the count; overflow pulses the non-sticky error.
   task automatic test_credit_balance();
      do_reset();
      for (int i = 0; i < 11; i++) drive(add_flit('0, 0, 3, {$urandom, $urandom}), '0);
      drive('0, '0);
      drive(add_flit('0, 0, 3, 64'h1234), '0);
      drive('0, add_crd('0, 0, 3));
      checks++;
      if (err !== 1'b0 || ns_err !== 1'b0 || cav[3] !== 1'b1) begin
         errors++;
         $display("FAIL bal_same_cycle: got err=%b nserr=%b cav3=%b exp 0 0 1", err, ns_err, cav[3]);
      end
      for (int i = 0; i < 11; i++) drive('0, add_crd('0, 0, 3));
      drive('0, '0);
      checks++;
      if (err !== 1'b0 || ns_err !== 1'b0) begin
         errors++;
         $display("FAIL bal_refill: got err=%b nserr=%b exp 0 0", err, ns_err);
      end
      drive('0, add_crd('0, 0, 3));
      checks++;
      if (ns_err !== 1'b1 || err !== 1'b1) begin
         errors++;
         $display("FAIL ovf_flag: got nserr=%b err=%b exp 1 1", ns_err, err);
      end
      drive('0, '0);
      checks++;
      if (ns_err !== 1'b0 || err !== 1'b1 || cav[3] !== 1'b1) begin
         errors++;
         $display("FAIL ovf_pulse_end: got nserr=%b err=%b cav3=%b exp 0 1 1", ns_err, err, cav[3]);
      end
   endtask

   task automatic test_idle();
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         drive('0, '0);
         checks++;
         if (idle[4] !== (i >= 8)) begin
            errors++;
            $display("FAIL idle_cycle%0d: got %b exp %b", i, idle[4], (i >= 8));
         end
      end
      drive('0, add_crd('0, 4, 0));
      checks++;
      if (idle !== 5'b01111 || idle !== exp_idle()) begin
         errors++;
         $display("FAIL idle_wake: got %b exp 01111", idle);
      end
      checks++;
      if (err !== err_m) begin
         errors++;
         $display("FAIL idle_err: got %b exp %b", err, err_m);
      end
   endtask

   // Randomised traffic; first phase credit-safe, second phase free to violate.
   task automatic test_random();
      logic [NP*CW-1:0] ch;
      logic [NP*FW-1:0] fc;
      do_reset();
      for (int i = 0; i < 500; i++) begin
         bit gated = (i < 300);
         ch = '0;
         fc = '0;
         for (int p = 0; p < NP; p++) begin
            int vc = int'($urandom_range(3, 0));
            int cv = int'($urandom_range(3, 0));
            if ($urandom_range(1, 0) == 1 && (!gated || cnt[p][vc] >= 2))
               ch = add_flit(ch, p, vc, {$urandom, $urandom});
            if ($urandom_range(2, 0) == 0 && (!gated || cnt[p][cv] < CPV))
               fc = add_crd(fc, p, cv);
         end
         drive(ch, fc);
         checks++;
         if (ch_out !== ch1 || fc_out !== fc1) begin
            errors++;
            $display("FAIL rand_path cyc%0d: got ch=%h fc=%h exp ch=%h fc=%h", i, ch_out, fc_out, ch1, fc1);
         end
         checks++;
         if (cav !== exp_cav()) begin
            errors++;
            $display("FAIL rand_cav cyc%0d: got %h exp %h", i, cav, exp_cav());
         end
         checks++;
         if (idle !== exp_idle()) begin
            errors++;
            $display("FAIL rand_idle cyc%0d: got %b exp %b", i, idle, exp_idle());
         end
         checks++;
         if (err !== err_m || ns_err !== err_ns_m) begin
            errors++;
            $display("FAIL rand_err cyc%0d: got err=%b nserr=%b exp %b %b", i, err, ns_err, err_m, err_ns_m);
         end
         checks++;
         if (p3_ch_out !== q3[0] || p3_fc_out !== fq3[0]) begin
            errors++;
            $display("FAIL rand_p3 cyc%0d: got ch=%h fc=%h exp ch=%h fc=%h", i, p3_ch_out, p3_fc_out,
                     q3[0], fq3[0]);
         end
      end
   endtask

   // Reset asserted mid-cycle flushes the three-stage pipeline for good.
   task automatic test_async_flush();
      logic [NP*CW-1:0] ch;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         ch = '0;
         for (int p = 0; p < NP; p++) ch = add_flit(ch, p, p % NV, {$urandom, $urandom});
         drive(ch, add_crd('0, i % NP, 1));
      end
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (p3_ch_out !== '0 || p3_fc_out !== '0 || ch_out !== '0 || fc_out !== '0) begin
         errors++;
         $display("FAIL flush_immediate: got p3ch=%h p3fc=%h ch=%h fc=%h exp 0",
                  p3_ch_out, p3_fc_out, ch_out, fc_out);
      end
      checks++;
      if (p3_cav !== {NP*NV{1'b1}} || p3_err !== 1'b0 || p3_idle !== '0) begin
         errors++;
         $display("FAIL flush_state: got cav=%h err=%b idle=%b exp ones 0 0", p3_cav, p3_err, p3_idle);
      end
      @(negedge clk);
      ch_in = '0;
      fc_in = '0;
      model_reset();
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive('0, '0);
         checks++;
         if (p3_ch_out !== '0 || p3_fc_out !== '0) begin
            errors++;
            $display("FAIL flush_replay%0d: got ch=%h fc=%h exp 0", i, p3_ch_out, p3_fc_out);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_back_to_back();
      test_underflow();
      test_credit_balance();
      test_idle();
      test_random();
      test_async_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
